// File: rtl/trackball_quad_gen.sv
// trackball_quad_gen
// Multi-axis trackball emulator. Each axis accumulates signed motion in
// quarter-step units from digital buttons, an analog stick or mouse deltas,
// then emits rate-limited dir/clk step pulses (one step = 4 units) at most
// once per two ticks. Mode 3 passes a real trackball's lines straight through.

module trackball_quad_gen #(
    parameter int NUM_AXES  = 2,
    parameter int ACC_W     = 12,
    parameter int PULSE_DIV = 1024,
    parameter int DEAD      = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [1:0]              mode_i,
    input  logic [1:0]              sensitivity_i,
    input  logic [NUM_AXES-1:0]     dig_pos_i,
    input  logic [NUM_AXES-1:0]     dig_neg_i,
    input  logic [NUM_AXES*8-1:0]   analog_i,
    input  logic [NUM_AXES*9-1:0]   delta_i,
    input  logic                    delta_strobe_i,
    input  logic [NUM_AXES-1:0]     dir_in_i,
    input  logic [NUM_AXES-1:0]     clk_in_i,
    output logic [NUM_AXES-1:0]     dir_out_o,
    output logic [NUM_AXES-1:0]     clk_out_o,
    output logic [NUM_AXES-1:0]     acc_sat_o
);

    // Sums are formed two bits wider than the accumulator so that the
    // largest contribution plus a full accumulator cannot wrap before the
    // clamp sees it.
    localparam int SW    = ACC_W + 2;
    localparam int CNT_W = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;

    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(PULSE_DIV - 1);
    localparam logic signed [SW-1:0] ACC_MAX  = SW'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SW-1:0] ACC_MIN  = -ACC_MAX;
    localparam logic signed [SW-1:0] STEP     = SW'(4);
    localparam logic [8:0]           DEAD_MAG = 9'(DEAD);

    typedef enum logic [1:0] {
        MODE_DIG   = 2'd0,
        MODE_ANA   = 2'd1,
        MODE_MOUSE = 2'd2,
        MODE_PASS  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } step_state_e;

    // ------------------------------------------------------------------
    // Contribution helpers
    // ------------------------------------------------------------------

    // Buttons: one scaled unit per tick; opposing buttons cancel out.
    function automatic logic signed [SW-1:0] dig_contrib(
        input logic       pos,
        input logic       neg,
        input logic [1:0] sens
    );
        logic signed [SW-1:0] unit_v;
        unit_v = SW'(1'b1);
        unit_v = unit_v << sens;
        if (pos && !neg) begin
            return unit_v;
        end else if (neg && !pos) begin
            return -unit_v;
        end else begin
            return '0;
        end
    endfunction

    // Analog: magnitude beyond the deadzone, coarsened by 16, then scaled.
    // The magnitude is 9 bits wide so that -128 yields +128.
    function automatic logic signed [SW-1:0] analog_contrib(
        input logic signed [7:0] raw,
        input logic [1:0]        sens
    );
        logic [8:0]           mag_v;
        logic [8:0]           over_v;
        logic signed [SW-1:0] val_v;
        if (raw[7]) begin
            mag_v = 9'd0 - {raw[7], raw};
        end else begin
            mag_v = {1'b0, raw};
        end
        if (mag_v <= DEAD_MAG) begin
            over_v = 9'd0;
        end else begin
            over_v = mag_v - DEAD_MAG;
        end
        val_v = SW'(over_v >> 4);
        val_v = val_v << sens;
        if (raw[7]) begin
            val_v = -val_v;
        end else begin
            val_v = val_v;
        end
        return val_v;
    endfunction

    // Mouse: sign-extended delta, scaled.
    function automatic logic signed [SW-1:0] mouse_contrib(
        input logic signed [8:0] raw,
        input logic [1:0]        sens
    );
        logic signed [SW-1:0] val_v;
        val_v = SW'(raw);
        val_v = val_v << sens;
        return val_v;
    endfunction

    // Symmetric clamp of a wide sum into the accumulator range.
    function automatic logic signed [ACC_W-1:0] clamp_acc(
        input logic signed [SW-1:0] x
    );
        if (x > ACC_MAX) begin
            return ACC_MAX[ACC_W-1:0];
        end else if (x < ACC_MIN) begin
            return ACC_MIN[ACC_W-1:0];
        end else begin
            return x[ACC_W-1:0];
        end
    endfunction

    // True when the clamp had to act on this sum.
    function automatic logic clamp_hit(
        input logic signed [SW-1:0] x
    );
        return (x > ACC_MAX) || (x < ACC_MIN);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              mode_q;
    logic signed [ACC_W-1:0] acc_q [NUM_AXES];
    logic signed [ACC_W-1:0] acc_d [NUM_AXES];
    step_state_e             state_q [NUM_AXES];
    step_state_e             state_d [NUM_AXES];
    logic [NUM_AXES-1:0]     dir_q, dir_d;
    logic [NUM_AXES-1:0]     clk_q, clk_d;
    logic [NUM_AXES-1:0]     sat_q, sat_d;
    logic                    tick;
    logic                    mode_chg;

    // Tick divider and detection of a mode switch against its registered copy.
    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        mode_chg = (mode_i != mode_q);
        if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end
    end

    // Per-axis accumulate / step FSM / passthrough next-state logic.
    always_comb begin
        logic signed [SW-1:0] acc_ext;
        logic signed [SW-1:0] in_v;
        logic signed [SW-1:0] cons_v;
        logic signed [SW-1:0] sum_v;
        dir_d   = dir_q;
        clk_d   = clk_q;
        sat_d   = sat_q;
        acc_ext = '0;
        in_v    = '0;
        cons_v  = '0;
        sum_v   = '0;
        for (int i = 0; i < NUM_AXES; i++) begin
            acc_d[i]   = acc_q[i];
            state_d[i] = state_q[i];
            acc_ext    = SW'(acc_q[i]);
            in_v       = '0;
            cons_v     = '0;
            sum_v      = '0;
            if (mode_chg) begin
                // Fresh start in the new mode; this cycle's inputs are dropped
                // and the last direction is kept for the core.
                acc_d[i]   = '0;
                sat_d[i]   = 1'b0;
                clk_d[i]   = 1'b0;
                state_d[i] = ST_LOW;
            end else if (mode_e'(mode_i) == MODE_PASS) begin
                acc_d[i]   = '0;
                state_d[i] = ST_LOW;
                dir_d[i]   = dir_in_i[i];
                clk_d[i]   = clk_in_i[i];
            end else begin
                case (mode_e'(mode_i))
                    MODE_DIG: begin
                        if (tick) begin
                            in_v = dig_contrib(dig_pos_i[i], dig_neg_i[i], sensitivity_i);
                        end else begin
                            in_v = '0;
                        end
                    end
                    MODE_ANA: begin
                        if (tick) begin
                            in_v = analog_contrib($signed(analog_i[8*i +: 8]), sensitivity_i);
                        end else begin
                            in_v = '0;
                        end
                    end
                    MODE_MOUSE: begin
                        if (delta_strobe_i) begin
                            in_v = mouse_contrib($signed(delta_i[9*i +: 9]), sensitivity_i);
                        end else begin
                            in_v = '0;
                        end
                    end
                    default: begin
                        in_v = '0;
                    end
                endcase

                // The step FSM only moves on ticks, so a full step takes two.
                if (tick) begin
                    case (state_q[i])
                        ST_LOW: begin
                            if (acc_ext >= STEP) begin
                                dir_d[i]   = 1'b1;
                                clk_d[i]   = 1'b1;
                                cons_v     = STEP;
                                state_d[i] = ST_HIGH;
                            end else if (acc_ext <= -STEP) begin
                                dir_d[i]   = 1'b0;
                                clk_d[i]   = 1'b1;
                                cons_v     = -STEP;
                                state_d[i] = ST_HIGH;
                            end else begin
                                state_d[i] = ST_LOW;
                            end
                        end
                        ST_HIGH: begin
                            clk_d[i]   = 1'b0;
                            state_d[i] = ST_LOW;
                        end
                        default: begin
                            clk_d[i]   = 1'b0;
                            state_d[i] = ST_LOW;
                        end
                    endcase
                end else begin
                    state_d[i] = state_q[i];
                end

                // New input and the consumed step land together in one update.
                sum_v    = acc_ext + in_v - cons_v;
                acc_d[i] = clamp_acc(sum_v);
                if (clamp_hit(sum_v)) begin
                    sat_d[i] = 1'b1;
                end else begin
                    sat_d[i] = sat_q[i];
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            mode_q <= 2'd0;
            dir_q  <= '0;
            clk_q  <= '0;
            sat_q  <= '0;
            for (int i = 0; i < NUM_AXES; i++) begin
                acc_q[i]   <= '0;
                state_q[i] <= ST_LOW;
            end
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_i;
            dir_q  <= dir_d;
            clk_q  <= clk_d;
            sat_q  <= sat_d;
            for (int i = 0; i < NUM_AXES; i++) begin
                acc_q[i]   <= acc_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign dir_out_o = dir_q;
    assign clk_out_o = clk_q;
    assign acc_sat_o = sat_q;

endmodule

// File: tb/tb_trackball_quad_gen.sv
// Directed bench for trackball_quad_gen with a short tick period.
// Expected step pulses (their direction) are queued per axis as stimulus is
// applied and consumed by a monitor on every rising clk_out edge.

module tb_trackball_quad_gen;

    localparam int NA = 2;
    localparam int PD = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      mode;
    logic [1:0]      sens;
    logic [NA-1:0]   dig_pos;
    logic [NA-1:0]   dig_neg;
    logic [NA*8-1:0] analog;
    logic [NA*9-1:0] delta;
    logic            delta_strobe;
    logic [NA-1:0]   dir_in;
    logic [NA-1:0]   clk_in;
    logic [NA-1:0]   dir_out;
    logic [NA-1:0]   clk_out;
    logic [NA-1:0]   acc_sat;

    always #5 clk = ~clk;

    trackball_quad_gen #(
        .NUM_AXES (NA),
        .ACC_W    (12),
        .PULSE_DIV(PD),
        .DEAD     (8)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .mode_i        (mode),
        .sensitivity_i (sens),
        .dig_pos_i     (dig_pos),
        .dig_neg_i     (dig_neg),
        .analog_i      (analog),
        .delta_i       (delta),
        .delta_strobe_i(delta_strobe),
        .dir_in_i      (dir_in),
        .clk_in_i      (clk_in),
        .dir_out_o     (dir_out),
        .clk_out_o     (clk_out),
        .acc_sat_o     (acc_sat)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int tb_cnt = 0;

    bit        exp0[$];
    bit        exp1[$];
    int        rise0[$];
    logic [3:0] pt_q[$];
    bit        mon_en = 1'b1;
    logic [NA-1:0] prev_clk = '0;

    // Bench-side copy of the tick divider
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) tb_cnt <= 0;
        else if (tb_cnt == PD - 1) tb_cnt <= 0;
        else tb_cnt <= tb_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_rise(input int a);
        bit e;
        checks++;
        assert (tb_cnt === 0) else begin
            errors++;
            $error("FAIL pulse_on_tick axis=%0d got_cnt=%0d exp_cnt=0", a, tb_cnt);
        end
        checks++;
        if (a == 0) begin
            rise0.push_back(cyc);
            assert (exp0.size() !== 0) else begin
                errors++;
                $error("FAIL extra_pulse axis=0 got=pulse exp=none");
            end
            if (exp0.size() != 0) begin
                e = exp0.pop_front();
                checks++;
                assert (dir_out[0] === e) else begin
                    errors++;
                    $error("FAIL pulse_dir axis=0 got=%b exp=%b", dir_out[0], e);
                end
            end
        end else begin
            assert (exp1.size() !== 0) else begin
                errors++;
                $error("FAIL extra_pulse axis=1 got=pulse exp=none");
            end
            if (exp1.size() != 0) begin
                e = exp1.pop_front();
                checks++;
                assert (dir_out[1] === e) else begin
                    errors++;
                    $error("FAIL pulse_dir axis=1 got=%b exp=%b", dir_out[1], e);
                end
            end
        end
    endtask

    // Pulse monitor: each rising clk_out consumes one expected direction
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            for (int a = 0; a < NA; a++) begin
                if (clk_out[a] === 1'b1 && prev_clk[a] === 1'b0) check_rise(a);
            end
        end
        prev_clk <= clk_out;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Move to a point halfway between ticks
    task automatic to_mid();
        do @(negedge clk); while (tb_cnt != PD / 2);
        #1;
    endtask

    task automatic push_n(input int n0, input bit d0, input int n1, input bit d1);
        for (int k = 0; k < n0; k++) exp0.push_back(d0);
        for (int k = 0; k < n1; k++) exp1.push_back(d1);
    endtask

    task automatic chk_drained(input string tag);
        chk(tag, 32'(exp0.size() + exp1.size()), 32'd0);
    endtask

    logic [3:0] pats[6] = '{4'b0010, 4'b1010, 4'b1000, 4'b0101, 4'b1111, 4'b1110};
    logic [3:0] pexp;

    initial begin
        reset = 1'b1; mode = 2'd2; sens = 2'd0;
        dig_pos = '0; dig_neg = '0; analog = '0; delta = '0; delta_strobe = 1'b0;
        dir_in = '0; clk_in = '0;
        wait_cyc(3);
        chk("reset_dir", 32'(dir_out), 32'd0);
        chk("reset_clk", 32'(clk_out), 32'd0);
        chk("reset_sat", 32'(acc_sat), 32'd0);
        reset = 1'b0;
        wait_cyc(2);

        // Mouse +3 at s=2 -> 12 units -> 3 steps; axis1 -2 -> 2 negative steps
        rise0.delete();
        sens = 2'd2;
        to_mid();
        delta = {9'h1FE, 9'd3};
        delta_strobe = 1'b1;
        push_n(3, 1'b1, 2, 1'b0);
        wait_cyc(1);
        delta_strobe = 1'b0; delta = '0;
        wait_cyc(8 * PD);
        chk_drained("t1_three_steps");
        chk("t1_rise_count", 32'(rise0.size()), 32'd3);
        if (rise0.size() >= 3) begin
            chk("t1_spacing_a", 32'(rise0[1] - rise0[0]), 32'(2 * PD));
            chk("t1_spacing_b", 32'(rise0[2] - rise0[1]), 32'(2 * PD));
        end
        chk("t1_dir_final", 32'(dir_out), 32'd1);

        // Fractional accumulation: three +1 strobes stay below a step
        sens = 2'd0;
        to_mid();
        delta = 18'd1;
        for (int k = 0; k < 3; k++) begin
            delta_strobe = 1'b1; wait_cyc(1);
            delta_strobe = 1'b0; wait_cyc(1);
        end
        wait_cyc(4 * PD);
        chk("t2_no_step_yet", 32'(clk_out), 32'd0);
        to_mid();
        delta_strobe = 1'b1;
        push_n(1, 1'b1, 0, 1'b0);
        wait_cyc(1);
        delta_strobe = 1'b0; delta = '0;
        wait_cyc(4 * PD);
        chk_drained("t2_fourth_strobe");

        // Digital, s=3: axis0 +8/tick, axis1 -8/tick for 20 ticks
        mode = 2'd0; sens = 2'd3;
        wait_cyc(1);
        to_mid();
        dig_pos = 2'b01; dig_neg = 2'b10;
        push_n(10, 1'b1, 10, 1'b0);
        wait_cyc(20 * PD);
        chk_drained("t3_dig_10_steps");
        // Both pressed contribute nothing; the 120 left over drains in 30 steps
        dig_pos = 2'b11; dig_neg = 2'b11;
        push_n(30, 1'b1, 30, 1'b0);
        wait_cyc(64 * PD);
        chk_drained("t3_both_pressed");
        dig_pos = '0; dig_neg = '0;

        // Saturation: +255 at s=3 -> 2040 per strobe, clamps at 2047
        mode = 2'd2; sens = 2'd3;
        wait_cyc(1);
        to_mid();
        chk("t4_sat_before", 32'(acc_sat), 32'd0);
        delta = 18'd255;
        delta_strobe = 1'b1;
        wait_cyc(4);
        delta_strobe = 1'b0; delta = '0;
        chk("t4_sat_set", 32'(acc_sat), 32'd1);
        push_n(1, 1'b1, 0, 1'b0);
        to_mid();
        chk("t4_clk_high", 32'(clk_out), 32'd1);
        mode = 2'd1;
        wait_cyc(1);
        chk("t4_sat_cleared", 32'(acc_sat), 32'd0);
        chk("t4_clk_dropped", 32'(clk_out), 32'd0);
        chk("t4_dir_held", 32'(dir_out), 32'd1);
        wait_cyc(3 * PD);
        chk_drained("t4_acc_cleared");

        // Analog: +8 sits in the deadzone; -128 gives -28 per tick
        sens = 2'd2;
        analog = {8'd0, 8'd8};
        wait_cyc(6 * PD);
        chk("t5_deadzone", 32'(clk_out), 32'd0);
        to_mid();
        analog = {8'd0, 8'h80};
        push_n(5, 1'b0, 0, 1'b0);
        wait_cyc(10 * PD);
        chk_drained("t5_analog_neg");

        // Passthrough: outputs follow the real lines one cycle later
        mon_en = 1'b0;
        mode = 2'd3; analog = '0;
        wait_cyc(1);
        chk("t6_mode_chg_clk", 32'(clk_out), 32'd0);
        chk("t6_mode_chg_dir", 32'(dir_out), 32'd0);
        for (int k = 0; k < 6; k++) begin
            {dir_in, clk_in} = pats[k];
            pt_q.push_back(pats[k]);
            wait_cyc(1);
            pexp = pt_q.pop_front();
            chk("t6_pass_follow", 32'({dir_out, clk_out}), 32'(pexp));
        end

        // Reset while clk_out is high
        reset = 1'b1;
        wait_cyc(1);
        chk("t6_reset_clk", 32'(clk_out), 32'd0);
        chk("t6_reset_dir", 32'(dir_out), 32'd0);
        chk("t6_reset_sat", 32'(acc_sat), 32'd0);
        reset = 1'b0;
        dir_in = '0; clk_in = '0;
        wait_cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trackball_quad_gen.md
Name: trackball_quad_gen

Overview:
Parameterised multi-axis trackball emulator and the successor to the single-trackball emulator. Each of NUM_AXES axes converts digital joystick, analog stick or mouse deltas into rate-limited dir/clk quadrature-style pulses for the game core's trackball inputs. A SNAC mode passes real trackball lines through. Sub-step fractional accumulation and saturation are behaviours the previous block lacked. The block sits between hps_io/USER_IN and the game core.

Parameters:
NUM_AXES, 2, number of independent axes (e.g. 2 = one ball H/V, 4 = two balls)
ACC_W, 12, signed accumulator width in quarter-step units (2 fractional bits)
PULSE_DIV, 1024, clk cycles per tick; the output FSM advances at most once per tick
DEAD, 8, analog deadzone magnitude

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
mode  in  2  0 digital, 1 analog, 2 mouse, 3 passthrough (SNAC)
sensitivity  in  2  0=25%, 1=50%, 2=100%, 3=200%
dig_pos  in  NUM_AXES  per-axis positive-direction button
dig_neg  in  NUM_AXES  per-axis negative-direction button
analog  in  NUM_AXES*8  per-axis signed analog value; axis i at [8i+7:8i]
delta  in  NUM_AXES*9  per-axis signed mouse delta; axis i at [9i+8:9i]
delta_strobe  in  1  one-cycle pulse; all delta lanes valid
dir_in  in  NUM_AXES  real trackball direction
clk_in  in  NUM_AXES  real trackball clock
dir_out  out  NUM_AXES  1 = positive
clk_out  out  NUM_AXES  step clock
acc_sat  out  NUM_AXES  sticky flag: accumulator saturated since last reset or mode change

Behaviour:
- Reset: all accumulators 0; dir_out, clk_out, acc_sat all 0; tick counter 0; every axis FSM in LOW.
- Tick: counter runs 0..PULSE_DIV-1; tick=1 in the cycle the counter equals PULSE_DIV-1, then the counter wraps to 0.
- Input contribution per axis (in = 0 unless stated), with s = sensitivity:
  - mode 0: on tick, in = +(1<<s) if only dig_pos is pressed, -(1<<s) if only dig_neg is pressed, 0 if both or neither.
  - mode 1: on tick, m = |analog| - DEAD, or 0 if |analog| <= DEAD; in = sign(analog) * ((m>>4)<<s). Compute |-128| as 128 (9-bit magnitude).
  - mode 2: on the delta_strobe cycle, in = delta<<s, sign-extended.
- Step = 4 units. Output FSM per axis, advancing only on tick:
  - LOW, acc >= 4: dir_out<=1, clk_out<=1, consume = +4, go to HIGH.
  - LOW, acc <= -4: dir_out<=0, clk_out<=1, consume = -4, go to HIGH.
  - LOW, otherwise: hold.
  - HIGH: clk_out<=0, go to LOW; dir_out held.
  - dir_out changes only on a LOW->HIGH transition. Maximum rate is one step per 2 ticks.
- Update: acc <= sat(acc + in - consume), evaluated in the same cycle, so simultaneous strobe/tick/consume all apply. Compute at ACC_W+2 bits. Clamp to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)]. Any clamp sets acc_sat[i]=1.
- Mode 3: dir_out <= dir_in and clk_out <= clk_in, registered with 1-cycle latency. Accumulators held at 0; FSM forced to LOW.
- Mode change (mode differs from its registered copy): on the next edge, accumulators cleared, acc_sat cleared, clk_out <= 0, FSM to LOW, dir_out unchanged. Inputs in that cycle are discarded.
- Sensitivity change: takes effect on the next contribution; the accumulator is retained.
- Reset asserted mid-pulse: clk_out drops to 0 on that edge.

Test Plan:
- Reset, then mode 2, s=2, delta[0]=+3 strobed once -> acc0=12; on 3 consecutive rising clk_out[0] edges, each 2 ticks apart, dir_out[0]=1; acc0 ends at 0; no fourth pulse.
- Mode 2, s=0, delta[0]=+1 strobed 3 times -> acc0=3, no pulse; 4th strobe -> exactly 1 pulse with dir_out=1, acc0 returns to 0.
- Mode 0, s=3, dig_neg[1]=1 for 20 ticks -> acc1 gains -8 per tick and loses 4 per pulse; 10 pulses with dir_out[1]=0; both buttons pressed -> contribution 0.
- Mode 2, ACC_W=12, s=3, delta[0]=+255 strobed 4 times -> acc0 clamps at 2047, acc_sat[0]=1; switch to mode 1 -> acc0=0, acc_sat[0]=0, clk_out[0]=0 next cycle.
- Mode 1, s=2, analog[0]=+8 -> no motion; analog[0]=-128 -> in = -(120>>4)<<2 = -28 per tick, pulses with dir_out[0]=0.
- Mode 3, toggle clk_in[1]/dir_in[1] -> clk_out[1]/dir_out[1] follow 1 cycle later; assert reset while clk_out=1 -> all outputs 0 on the next edge.
